// File: rtl/lsu_pkg.sv
// Shared load/store-unit definitions: RISC-V funct3 encodings, sequencer
// states and the access-size decode used by byte_mem_sequencer.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  // Number of bytes touched by a request; 0 marks an illegal funct3.
  function automatic logic [2:0] size_bytes(input logic we, input logic [2:0] funct3);
    logic [2:0] n;
    case (funct3)
      F3_B:    n = 3'd1;
      F3_H:    n = 3'd2;
      F3_W:    n = 3'd4;
      F3_BU:   n = we ? 3'd0 : 3'd1;
      F3_HU:   n = we ? 3'd0 : 3'd2;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational load-result formatter: sign/zero-extends the assembled
// little-endian word according to the load funct3.
module lsu_load_extend
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    rdata = word;
    case (funct3)
      F3_B:    rdata = {{(XLEN-8){word[7]}}, word[7:0]};
      F3_H:    rdata = {{(XLEN-16){word[15]}}, word[15:0]};
      F3_BU:   rdata = {{(XLEN-8){1'b0}}, word[7:0]};
      F3_HU:   rdata = {{(XLEN-16){1'b0}}, word[15:0]};
      default: rdata = word;
    endcase
  end

endmodule

// File: rtl/byte_mem_sequencer.sv
// Splits one RISC-V load/store into 1, 2 or 4 single-byte accesses on an
// 8-bit asynchronous memory and returns the extended load result.
module byte_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_data_in,
  output logic              mem_rden,
  output logic              mem_wren,
  input  logic [7:0]        mem_data_out
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   asm_q, asm_d;

  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [7:0]        mem_data_in_q, mem_data_in_d;
  logic              mem_rden_q, mem_rden_d;
  logic              mem_wren_q, mem_wren_d;

  logic [2:0]        req_nbytes;
  logic              req_bad;
  logic [XLEN-1:0]   ext_rdata;

  assign req_nbytes = size_bytes(req_we, req_funct3);
  assign req_bad    = (req_nbytes == 3'd0) || (|req_addr[XLEN-1:ADDR_W]);

  // Fed with the next assembly value so the last captured byte is included.
  lsu_load_extend #(.XLEN(XLEN)) u_extend (
    .word   (asm_d),
    .funct3 (funct3_d),
    .rdata  (ext_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    err_d    = err_q;
    asm_d    = asm_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d   = req_addr[ADDR_W-1:0];
          wdata_d  = req_wdata;
          we_d     = req_we;
          funct3_d = req_funct3;
          nbytes_d = req_nbytes;
          err_d    = req_bad;
          cnt_d    = 2'd0;
          asm_d    = '0;
          state_d  = req_bad ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (!we_q) asm_d[{cnt_q, 3'b000} +: 8] = mem_data_out;
        if ({1'b0, cnt_q} == nbytes_q - 3'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered: derive them from the next-state values.
    req_ready_d   = (state_d == IDLE);
    rsp_valid_d   = (state_d == RESP);
    rsp_err_d     = (state_d == RESP) && err_d;
    rsp_rdata_d   = ((state_d == RESP) && !err_d && !we_d) ? ext_rdata : '0;
    mem_rden_d    = (state_d == ACCESS) && !we_d;
    mem_wren_d    = (state_d == ACCESS) && we_d;
    mem_address_d = (state_d == ACCESS) ? base_d + ADDR_W'(cnt_d) : '0;
    mem_data_in_d = mem_wren_d ? wdata_d[{cnt_d, 3'b000} +: 8] : '0;
  end

  // Async reset clears the strobe flops directly, aborting any access at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      nbytes_q      <= '0;
      base_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      funct3_q      <= '0;
      err_q         <= 1'b0;
      asm_q         <= '0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_rdata_q   <= '0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_rden_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      nbytes_q      <= nbytes_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      err_q         <= err_d;
      asm_q         <= asm_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_rdata_q   <= rsp_rdata_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rden_q    <= mem_rden_d;
      mem_wren_q    <= mem_wren_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign mem_address = mem_address_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_rden    = mem_rden_q;
  assign mem_wren    = mem_wren_q;

endmodule

// File: tb/tb_byte_mem_sequencer.sv
// Scoreboard bench for byte_mem_sequencer: driver pushes expected strobes and
// responses from a byte-array reference model; a negedge monitor checks them.
module tb_byte_mem_sequencer;

  localparam int ADDR_W = 13;
  localparam int XLEN   = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              rsp_valid;
  logic [XLEN-1:0]   rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_data_in;
  logic              mem_rden;
  logic              mem_wren;
  logic [7:0]        mem_data_out;

  always #5 clk = ~clk;

  byte_mem_sequencer #(.ADDR_W(ADDR_W), .XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_rden     (mem_rden),
    .mem_wren     (mem_wren),
    .mem_data_out (mem_data_out)
  );

  function automatic logic [7:0] seed_byte(input int i);
    return 8'((i * 37) ^ (i >> 5));
  endfunction

  // Memory driven by the DUT; seeded on the first clock edge.
  logic [7:0] mem [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  bit seeded = 0;
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= seed_byte(i);
      seeded <= 1;
    end else if (mem_wren) begin
      mem[mem_address] <= mem_data_in;
    end
  end

  typedef struct { logic [31:0] rdata; logic err; int cyc; } rsp_t;
  typedef struct { logic [12:0] addr; logic we; logic [7:0] data; } stb_t;
  rsp_t rsp_q[$];
  stb_t stb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_size(input bit we, input logic [2:0] f3);
    if (we) begin
      case (f3)
        3'b000: return 1;
        3'b001: return 2;
        3'b010: return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Monitor: every cycle check bus invariants, pop strobes and responses.
  always @(negedge clk) begin
    if (!rst && seeded) begin
      chk(!(mem_rden && mem_wren), "strobe_exclusive", {mem_rden, mem_wren}, 0);
      chk(!(rsp_valid && req_ready), "rsp_in_idle", {rsp_valid, req_ready}, 0);
      if (!mem_rden && !mem_wren) begin
        chk(mem_address == 0 && mem_data_in == 0, "idle_bus", {mem_address, mem_data_in}, 0);
      end else if (stb_q.size() == 0) begin
        chk(0, "unexpected_strobe", {mem_wren, mem_address}, 0);
      end else begin
        stb_t e;
        e = stb_q.pop_front();
        chk(mem_address == e.addr, "strobe_addr", mem_address, e.addr);
        chk(mem_wren == e.we, "strobe_dir", mem_wren, e.we);
        if (e.we) chk(mem_data_in == e.data, "store_byte", mem_data_in, e.data);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          chk(0, "unexpected_rsp", rsp_rdata, 0);
        end else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk(rsp_rdata == r.rdata, "rsp_rdata", rsp_rdata, r.rdata);
          chk(rsp_err == r.err, "rsp_err", rsp_err, r.err);
          chk(cyc == r.cyc, "rsp_latency", cyc, r.cyc);
        end
      end
    end
  end

  // Called just after a negedge; returns after the next negedge with
  // req_valid still asserted (caller drops it or issues again).
  task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output int acc);
    int n;
    bit err;
    logic [31:0] v;
    logic [31:0] rd;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      chk(0, "accept_timeout", req_ready, 1);
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    n   = ref_size(we, f3);
    err = (n == 0) || (addr >= 32'(DEPTH));
    if (err) begin
      rsp_q.push_back('{rdata: 32'h0, err: 1'b1, cyc: acc});
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) begin
        int a;
        logic [7:0] b;
        a = (int'(addr) + i) % DEPTH;
        b = 8'(wdata >> (8 * i));
        if (we) begin
          stb_q.push_back('{addr: 13'(a), we: 1'b1, data: b});
          ref_mem[a] = b;
        end else begin
          stb_q.push_back('{addr: 13'(a), we: 1'b0, data: 8'h00});
          v = v + (32'(ref_mem[a]) << (8 * i));
        end
      end
      rd = v;
      if (we) rd = 0;
      else if (f3 == 3'b000 && v >= 128)   rd = v - 32'd256;
      else if (f3 == 3'b001 && v >= 32768) rd = v - 32'd65536;
      rsp_q.push_back('{rdata: rd, err: 1'b0, cyc: acc + n});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int a1, a2, a3, a0;
  logic [7:0] keep2, keep3;
  int mm;

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_byte(i);
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    rst = 1'b1;
    #1;
    chk(req_ready == 1'b1, "reset_ready", req_ready, 1);
    chk(rsp_valid == 0 && rsp_err == 0 && rsp_rdata == 0, "reset_rsp", rsp_rdata, 0);
    chk(mem_rden == 0 && mem_wren == 0 && mem_address == 0, "reset_mem", {mem_rden, mem_wren, mem_address}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    issue(1, 3'b010, 32'h0000_000A, 32'hDEADBEEF, a0); idle(6);
    issue(0, 3'b010, 32'h0000_000A, 32'h0, a0);        idle(6);
    issue(0, 3'b000, 32'h0000_000D, 32'h0, a0);        idle(3);
    issue(0, 3'b100, 32'h0000_000D, 32'h0, a0);        idle(3);
    issue(1, 3'b001, 32'h0000_1FFF, 32'h0000_8001, a0); idle(4);
    issue(0, 3'b001, 32'h0000_1FFF, 32'h0, a0);        idle(4);
    issue(0, 3'b101, 32'h0000_1FFF, 32'h0, a0);        idle(4);
    issue(0, 3'b010, 32'h0000_2000, 32'h0, a0);        idle(3);
    issue(1, 3'b011, 32'h0000_0010, 32'h1234_5678, a0); idle(3);
    issue(1, 3'b100, 32'h0000_0010, 32'h1234_5678, a0); idle(3);

    // Back-to-back stores with req_valid held
    issue(1, 3'b000, 32'h0000_0040, 32'h0000_00A1, a1);
    issue(1, 3'b000, 32'h0000_0041, 32'h0000_00B2, a2);
    issue(1, 3'b000, 32'h0000_0042, 32'h0000_00C3, a3);
    idle(4);
    chk(a2 - a1 == 3, "b2b_gap_1", a2 - a1, 3);
    chk(a3 - a2 == 3, "b2b_gap_2", a3 - a2, 3);
    issue(0, 3'b010, 32'h0000_0040, 32'h0, a0); idle(6);

    // Reset during byte 2 of a word store
    keep2 = ref_mem[32'h102];
    keep3 = ref_mem[32'h103];
    issue(1, 3'b010, 32'h0000_0100, 32'h1122_3344, a0);
    req_valid = 1'b0;
    for (int k = 0; k < 10 && !(mem_wren && mem_address == 13'h102); k++) @(negedge clk);
    chk(mem_wren && mem_address == 13'h102, "reach_byte2", {mem_wren, mem_address}, {1'b1, 13'h102});
    #2 rst = 1'b1;
    #1;
    chk(mem_wren == 0 && mem_rden == 0, "abort_strobe", {mem_rden, mem_wren}, 0);
    chk(req_ready == 1'b1, "abort_ready", req_ready, 1);
    chk(rsp_valid == 1'b0, "abort_no_rsp", rsp_valid, 0);
    stb_q.delete();
    rsp_q.delete();
    ref_mem[32'h102] = keep2;
    ref_mem[32'h103] = keep3;
    @(negedge clk);
    rst = 1'b0;
    idle(6);
    issue(0, 3'b010, 32'h0000_0100, 32'h0, a0); idle(6);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      bit we;
      logic [2:0] f3;
      logic [31:0] addr;
      int sel;
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: f3 = 3'b000;
        3, 4:    f3 = 3'b001;
        5, 6:    f3 = 3'b010;
        7:       f3 = 3'b100;
        8:       f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      addr = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) addr = 32'(DEPTH - $urandom_range(1, 3));
      issue(we, f3, addr, $urandom, a0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);

    for (int k = 0; k < 50 && rsp_q.size() != 0; k++) @(negedge clk);
    chk(rsp_q.size() == 0, "rsp_drain", rsp_q.size(), 0);
    chk(stb_q.size() == 0, "strobe_drain", stb_q.size(), 0);
    mm = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) mm++;
    chk(mm == 0, "mem_image", mm, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/byte_mem_sequencer.md
Name: byte_mem_sequencer

Overview:
- Initiator-side controller for the 8-bit asynchronous data memory (13-bit byte address, rden/wren strobes, combinational data_out).
- Accepts one RISC-V load/store request from the MEM stage and turns it into 1, 2 or 4 single-byte memory accesses, one per clock, in little-endian order.
- Returns a sign/zero-extended 32-bit load result; stalls the pipeline via req_ready while busy.

Parameters:
- ADDR_W, 13: memory byte-address width; bytes wrap modulo 2^ADDR_W.
- XLEN, 32: CPU data and address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle, can accept.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/signedness).
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data, bits [8n-1:0] used.
- rsp_valid  out  1  one-cycle pulse: access finished.
- rsp_rdata  out  XLEN  extended load data; 0 for stores/errors.
- rsp_err  out  1  valid with rsp_valid: request rejected.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  8  to memory data_in.
- mem_rden  out  1  to memory rden.
- mem_wren  out  1  to memory wren.
- mem_data_out  in  8  from memory data_out (combinational).

Behaviour:
- Reset, asynchronous: state IDLE, byte counter 0, assembly register 0. All outputs 0, except req_ready = 1.
- Reset mid-operation: mem_wren and mem_rden drop immediately, with no wait for the edge. Bytes already written stay written. No rsp_valid is produced for the aborted request.
- Handshake: a request is accepted at the rising edge where req_valid && req_ready. The request fields are registered at that edge. The requester may change its inputs afterwards.
- Size decode:
  - Loads: 000 LB(1), 001 LH(2), 010 LW(4), 100 LBU(1), 101 LHU(2).
  - Stores: 000 SB(1), 001 SH(2), 010 SW(4).
- Error path. The request is rejected if either condition holds:
  - any other funct3;
  - req_addr[XLEN-1:ADDR_W] ≠ 0.
  On rejection: no memory strobe is ever asserted; state goes to RESP; the next cycle gives rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Misaligned addresses are legal. Byte i goes to (addr + i) mod 2^ADDR_W, so 0x1FFF+1 wraps to 0x0000.
- State ACCESS, entered after acceptance (N bytes):
  - In cycle i (i = 0..N-1): mem_address = base + i. Exactly one of mem_rden or mem_wren is 1.
  - For stores, mem_data_in = req_wdata[8i+7:8i].
  - For loads, mem_data_out is captured into assembly byte i at the end of the cycle.
  - Address and data are stable for the whole strobe cycle; the strobe is 1 for exactly one cycle per byte.
  - After byte N-1: state RESP.
- State RESP (one cycle): rsp_valid = 1, rsp_err = 0, req_ready = 0. rsp_rdata is set as follows:
  - LB/LH: sign-extended from bit 7/15.
  - LBU/LHU: zero-extended.
  - LW: raw value.
  - Stores: 0.
- Next state after RESP is IDLE.
- Latency, from the accept edge to rsp_valid: N+1 cycles for valid requests, 1 cycle for errors.
- Throughput: one request per N+2 cycles, because req_ready is 1 only in IDLE.
- mem_address, mem_data_in are 0 whenever no strobe is asserted.
- mem_rden and mem_wren are never 1 in the same cycle.
- req_ready = (state == IDLE). rsp_valid is never asserted in IDLE.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - state enum IDLE/ACCESS/RESP;
  - size-decode function returning byte count (0 = illegal).
- One combinational sub-module, lsu_load_extend: inputs assembled 32-bit word and funct3; output extended rsp_rdata. It is reusable by the future cached LSU.

Test Plan:
- SW 0xDEADBEEF @0x000A -> cycles 1-4: wren at 0x0A..0x0D with data EF, BE, AD, DE; rsp_valid 5 cycles after accept; rsp_err 0.
- LW @0x000A after that store -> rden at 0x0A..0x0D; rsp_rdata 0xDEADBEEF. LB @0x000D -> 0xFFFFFFDE; LBU @0x000D -> 0x000000DE.
- SH 0x8001 @0x1FFF -> wren at 0x1FFF (01), then 0x0000 (80); LH @0x1FFF -> 0xFFFF8001; LHU -> 0x00008001.
- LW @0x00002000 (out of range) and funct3 = 011 -> no rden/wren; rsp_valid+rsp_err the cycle after accept; rdata 0.
- Hold req_valid with 3 back-to-back SB requests -> req_ready low during ACCESS/RESP; the second request is accepted exactly 3 cycles after the first; the memory shows each byte once.
- Assert rst during byte 2 of an SW -> strobes drop in the same timestep; req_ready = 1; no rsp_valid; bytes 0-1 are written and bytes 2-3 are unchanged.
